unidade_de_busca: RTL



---
 rtl/unidade_de_busca.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/unidade_de_busca.sv
// Fetch-control stage: owns the program counter, decodes jump/halt/in opcodes,
// applies stall/branch/input-wait/halt priority and counts retired instructions.
module unidade_de_busca #(
    parameter int unsigned PC_WIDTH    = 26,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_SIZE    = 150
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instrucao,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                in_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                waiting_input,
    output logic                fault,
    output logic [31:0]         retired
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    localparam logic [5:0] OP_JUMP = 6'b011111;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_IN   = 6'b100010;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_WAIT_IN,
        S_HALTED
    } state_t;

    state_t              r_state;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_halted;
    logic                r_waiting;
    logic                r_fault;
    logic [31:0]         r_retired;

    state_t              w_state_next;
    logic [BOOT_W-1:0]   w_boot_next;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_try;
    logic                w_retire;
    logic                w_fault_hit;
    logic                w_boot_done;
    logic [5:0]          w_opcode;
    logic                w_halted_next;
    logic                w_waiting_next;
    logic                w_fault_next;
    logic [31:0]         w_retired_next;

    assign w_opcode    = instrucao[31:26];
    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_boot_done = (32'(r_boot_cnt) + 32'd1) >= BOOT_CYCLES;

    // State register plus all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= '0;
            r_pc       <= PC_WIDTH'(RESET_PC);
            r_halted   <= 1'b0;
            r_waiting  <= 1'b0;
            r_fault    <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_boot_cnt <= w_boot_next;
            r_pc       <= w_pc_next;
            r_halted   <= w_halted_next;
            r_waiting  <= w_waiting_next;
            r_fault    <= w_fault_next;
            r_retired  <= w_retired_next;
        end
    end

    // Next-state / next-pc selection; a candidate target is range-checked at the end
    always_comb begin
        w_state_next = r_state;
        w_boot_next  = r_boot_cnt;
        w_pc_next    = r_pc;
        w_target     = w_pc_inc;
        w_try        = 1'b0;
        w_retire     = 1'b0;
        w_fault_hit  = 1'b0;

        case (r_state)
            S_BOOT: begin
                if (w_boot_done) begin
                    w_state_next = S_RUN;
                end else begin
                    w_boot_next = r_boot_cnt + BOOT_W'(1);
                end
            end
            S_RUN: begin
                if (stall) begin
                    w_state_next = S_RUN;
                end else if (w_opcode == OP_HALT) begin
                    w_state_next = S_HALTED;
                    w_retire     = 1'b1;
                end else if (w_opcode == OP_JUMP) begin
                    w_target = PC_WIDTH'(instrucao[25:0]);
                    w_try    = 1'b1;
                end else if (branch_taken) begin
                    w_target = branch_target;
                    w_try    = 1'b1;
                end else if ((w_opcode == OP_IN) && !in_valid) begin
                    w_state_next = S_WAIT_IN;
                end else begin
                    w_target = w_pc_inc;
                    w_try    = 1'b1;
                end
            end
            S_WAIT_IN: begin
                if (!stall && in_valid) begin
                    w_state_next = S_RUN;
                    w_target     = w_pc_inc;
                    w_try        = 1'b1;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_HALTED;
            end
        endcase

        if (w_try) begin
            if (32'(w_target) >= MEM_SIZE) begin
                w_fault_hit  = 1'b1;
                w_state_next = S_HALTED;
            end else begin
                w_pc_next = w_target;
                w_retire  = 1'b1;
            end
        end
    end

    // Next values of the registered status outputs
    always_comb begin
        w_halted_next  = (w_state_next == S_HALTED);
        w_waiting_next = (w_state_next == S_WAIT_IN);
        w_fault_next   = r_fault | w_fault_hit;
        w_retired_next = r_retired + (w_retire ? 32'd1 : 32'd0);
    end

    assign pc            = r_pc;
    assign halted        = r_halted;
    assign waiting_input = r_waiting;
    assign fault         = r_fault;
    assign retired       = r_retired;

endmodule
